// File: rtl/stack_pkg.sv
// Shared constants, operation encoding and FSM state type for the stack arbiter.
package stack_pkg;
    localparam int STACK_DEPTH = 16;
    localparam int DATA_W      = 32;
    localparam int LAST_W      = 6;
    localparam int MAX_REQ     = 4;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Position of the set bit in a one-hot vector; 0 when nothing is set.
    function automatic logic [1:0] onehot_to_index(input logic [MAX_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first active request at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack between several requesters: round-robin grant, one stack
// operation per grant, full/empty screened up front so the stack never sees a bad op.
module stack_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = stack_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_rw,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic                         flush,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err,
    output logic                         busy,
    output logic [7:0]                   err_cnt,
    output logic                         stk_reset,
    output logic                         stk_op_valid,
    output logic                         stk_read_write,
    output logic [DATA_W-1:0]            stk_data_in,
    input  logic [DATA_W-1:0]            stk_data_out,
    input  logic                         stk_empty,
    input  logic                         stk_full,
    input  logic [stack_pkg::LAST_W-1:0] stk_last
);
    import stack_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic               op_rw;
    logic [DATA_W-1:0]  op_data;
    logic               flush_pulse;
    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_rw;
    logic [DATA_W-1:0]  pick_data;
    logic               pick_bad;
    logic               full_now;
    logic               empty_now;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (pick)
    );

    // Either the flag or the occupancy count is enough to refuse an operation.
    assign full_now  = stk_full || (stk_last >= LAST_W'(STACK_DEPTH));
    assign empty_now = stk_empty || (stk_last == '0);
    assign stk_reset = reset || flush_pulse;

    always_comb begin
        pick_idx  = PTR_W'(onehot_to_index(MAX_REQ'(pick)));
        pick_rw   = req_rw[pick_idx];
        pick_data = req_data[pick_idx*DATA_W +: DATA_W];
        pick_bad  = (pick_rw == OP_PUSH) ? full_now : empty_now;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= '0;
            owner          <= '0;
            op_rw          <= OP_PUSH;
            op_data        <= '0;
            flush_pulse    <= 1'b0;
            grant          <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            busy           <= 1'b0;
            err_cnt        <= 8'd0;
            stk_op_valid   <= 1'b0;
            stk_read_write <= OP_PUSH;
            stk_data_in    <= '0;
        end else begin
            flush_pulse  <= 1'b0;
            stk_op_valid <= 1'b0;
            rsp_valid    <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        state       <= FLUSH;
                        flush_pulse <= 1'b1;
                        busy        <= 1'b1;
                    end else if (|req) begin
                        owner   <= pick_idx;
                        op_rw   <= pick_rw;
                        op_data <= pick_data;
                        grant   <= pick;
                        busy    <= 1'b1;
                        // Illegal operations skip the stack and answer immediately.
                        if (pick_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            state          <= ISSUE;
                            stk_op_valid   <= 1'b1;
                            stk_read_write <= pick_rw;
                            stk_data_in    <= pick_data;
                        end
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= (op_rw == OP_POP) ? stk_data_out : op_data;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= '0;
                    // The requester just served drops to lowest priority.
                    ptr   <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
                    if (rsp_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= '0;
                end
            endcase
        end
    end
endmodule
